bp_update_queue: RTL
====================

Name: bp_update_queue

Overview:
- Decouples the commit stage from the branch predictor's training port.
- Commit can retire up to two branches per cycle. The predictor accepts one update per cycle.
- This block buffers resolved branch records in program order and drains them one per cycle onto the predictor's update interface (update_valid / pc_retire / actual_taken / actual_target / is_branch_retire / is_indirect_retire).
- Predictor updates are hints, so records that arrive when the queue is full are dropped and counted, never stalled.

Parameters:
- DEPTH, 8, number of queue entries; power of two, at least 4.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock; the block has one clock.
- rst  in  1  reset; reset is synchronous and active-high.
- s0_valid_i  in  1  slot-0 retiring branch record valid (older).
- s0_pc_i  in  64  slot-0 branch PC.
- s0_taken_i  in  1  slot-0 resolved direction.
- s0_target_i  in  64  slot-0 resolved target.
- s0_indirect_i  in  1  slot-0 is an indirect branch.
- s1_valid_i  in  1  slot-1 record valid (younger).
- s1_pc_i  in  64  slot-1 branch PC.
- s1_taken_i  in  1  slot-1 resolved direction.
- s1_target_i  in  64  slot-1 resolved target.
- s1_indirect_i  in  1  slot-1 is an indirect branch.
- hold_i  in  1  pause draining (predictor busy); no pop while high.
- enq_ready_o  out  1  queue can accept two records this cycle.
- update_valid_o  out  1  head record presented to predictor.
- pc_retire_o  out  64  head PC.
- actual_taken_o  out  1  head direction.
- actual_target_o  out  64  head target.
- is_branch_retire_o  out  1  equals update_valid_o.
- is_indirect_retire_o  out  1  head indirect flag, gated by update_valid_o.
- count_o  out  $clog2(DEPTH+1)  current occupancy.
- drop_cnt_o  out  DROP_W  saturating count of dropped records.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries, each {pc, taken, target, indirect}.
  - Wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - Count is tracked explicitly.
- Reset (rst=1 at a clock edge):
  - Pointers, count and drop_cnt go to 0.
  - enq_ready_o=1 and update_valid_o=0.
  - All data outputs read 0 while invalid, because they are gated by update_valid_o.
  - A reset mid-drain discards all entries. Entry contents need not be cleared.
- enq_ready_o = (count <= DEPTH-2). It is computed from the registered count only, with no credit taken for a same-cycle pop.
- Enqueue when enq_ready_o=1:
  - Both valid: s0 is written at wr_ptr and s1 at wr_ptr+1; wr_ptr advances by 2.
  - Only one slot valid (s0 or s1 alone): that record is written at wr_ptr; wr_ptr advances by 1. There is no hole.
  - Neither valid: no write.
- Enqueue when enq_ready_o=0:
  - All presented valid records are dropped; there is no partial acceptance.
  - drop_cnt increments by s0_valid_i + s1_valid_i and saturates at all-ones.
  - Queue state is unchanged apart from any pop.
- Dequeue:
  - pop = (count != 0) && !hold_i.
  - update_valid_o = pop, driven combinationally from the registered count and hold_i.
  - Head fields are read combinationally from the entry at rd_ptr.
  - On pop, rd_ptr advances by 1 at the clock edge.
- Latency: a record accepted at edge N is presented at the earliest in the cycle after edge N. There is no bypass from input to output.
- Simultaneous push and pop: count_next = count + pushes - pop. Pops and pushes in the same cycle are legal at any occupancy permitted by enq_ready_o.
- Ordering: predictor updates leave strictly in retirement order, with s0 before s1 within a cycle.
- Hold: while hold_i=1, the head stays stable, update_valid_o=0, and enqueue continues normally.
- Full: count=DEPTH is reachable only via count=DEPTH-2 plus two pushes with no pop. At count >= DEPTH-1, enq_ready_o=0.

Test Plan:
- Reset, then s0 only: pc=0x1000, taken=1, target=0x2000 in cycle 0. Required: cycle 1 shows update_valid_o=1 with pc_retire_o=0x1000, actual_target_o=0x2000, is_branch_retire_o=1. Cycle 2 shows update_valid_o=0 and count_o=0.
- Dual push: s0 pc=0x100, s1 pc=0x200 (indirect, target 0x900). Required: output order 0x100 then 0x200 on consecutive cycles. is_indirect_retire_o=1 only on the second.
- s1 only, pc=0x300, with s0 invalid. Required: stored compactly; count_o=1; next cycle presents pc 0x300.
- Overflow with hold_i=1 and four dual pushes (DEPTH=8). Required: count_o reaches 8; enq_ready_o=0 after count 7. A fifth dual push gives drop_cnt_o=2 and count_o=8. On release of hold, 8 updates emerge in order.
- Steady state at count=6: one dual push and one pop per cycle. Required: count_o goes 6→7, then enq_ready_o=0. Further pushes drop while pops continue; wrap-around preserves order across the pointer wrap.
- Assert rst with count=5 during a drain. Required: next cycle count_o=0, update_valid_o=0, drop_cnt_o=0, enq_ready_o=1.

Source files
------------

// File: rtl/bp_update_queue.sv
// bp_update_queue: buffers resolved branch records from a two-wide commit stage
// and drains them one per cycle onto the branch predictor's update interface.
// Predictor updates are hints: records that arrive while the queue cannot take
// both slots are dropped and counted rather than stalling commit.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   s0_*_i                   older retiring branch record (valid/pc/taken/target/indirect)
//   s1_*_i                   younger retiring branch record
//   hold_i                   predictor busy; suppresses the pop
//   enq_ready_o              queue has room for two records this cycle
//   update_valid_o           head record presented (and popped) this cycle
//   pc_retire_o, actual_taken_o, actual_target_o, is_indirect_retire_o
//                            head record fields, zero when update_valid_o=0
//   is_branch_retire_o       mirror of update_valid_o
//   count_o                  current occupancy
//   drop_cnt_o               saturating count of dropped records
module bp_update_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s0_valid_i,
  input  logic [63:0]                s0_pc_i,
  input  logic                       s0_taken_i,
  input  logic [63:0]                s0_target_i,
  input  logic                       s0_indirect_i,
  input  logic                       s1_valid_i,
  input  logic [63:0]                s1_pc_i,
  input  logic                       s1_taken_i,
  input  logic [63:0]                s1_target_i,
  input  logic                       s1_indirect_i,
  input  logic                       hold_i,
  output logic                       enq_ready_o,
  output logic                       update_valid_o,
  output logic [63:0]                pc_retire_o,
  output logic                       actual_taken_o,
  output logic [63:0]                actual_target_o,
  output logic                       is_branch_retire_o,
  output logic                       is_indirect_retire_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [DROP_W-1:0]          drop_cnt_o
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = $clog2(DEPTH + 1);
  localparam int unsigned DropSumW = DROP_W + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic        taken;
    logic [63:0] target;
    logic        indirect;
  } entry_t;

  entry_t              mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic                enq_ready;
  logic                pop;
  logic [1:0]          n_in;
  logic [1:0]          push_n;
  logic [PtrW-1:0]     wr_idx1;
  logic [DropSumW-1:0] drop_sum;
  entry_t              head;

  always_comb begin
    // Readiness looks only at the registered count; a same-cycle pop earns no credit.
    enq_ready = (count_q <= CntW'(DEPTH - 2));
    pop       = (count_q != '0) && !hold_i;
    n_in      = {1'b0, s0_valid_i} + {1'b0, s1_valid_i};
    push_n    = enq_ready ? n_in : 2'd0;
    // s1 lands directly after s0, or at wr_ptr itself when s0 is absent (no hole).
    wr_idx1   = wr_ptr_q + PtrW'(s0_valid_i);

    wr_ptr_d  = wr_ptr_q + PtrW'(push_n);
    rd_ptr_d  = rd_ptr_q + PtrW'(pop);
    count_d   = count_q + CntW'(push_n) - CntW'(pop);

    drop_sum  = {1'b0, drop_q} + DropSumW'(n_in);
    drop_d    = drop_q;
    if (!enq_ready) begin
      drop_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage is not reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (!rst && enq_ready) begin
      if (s0_valid_i) begin
        mem_q[wr_ptr_q] <= '{pc: s0_pc_i, taken: s0_taken_i, target: s0_target_i,
                             indirect: s0_indirect_i};
      end
      if (s1_valid_i) begin
        mem_q[wr_idx1] <= '{pc: s1_pc_i, taken: s1_taken_i, target: s1_target_i,
                            indirect: s1_indirect_i};
      end
    end
  end

  always_comb begin
    head                 = mem_q[rd_ptr_q];
    enq_ready_o          = enq_ready;
    update_valid_o       = pop;
    is_branch_retire_o   = pop;
    pc_retire_o          = pop ? head.pc : 64'd0;
    actual_taken_o       = pop & head.taken;
    actual_target_o      = pop ? head.target : 64'd0;
    is_indirect_retire_o = pop & head.indirect;
    count_o              = count_q;
    drop_cnt_o           = drop_q;
  end

endmodule
